logic_unit_pipe: RTL

Parametrised, pipelined bitwise logic unit. It generalises the basic AND/OR/NOT gate network to a WIDTH-bit datapath with eight selectable operations, one of which is the compound function (a AND b) OR (NOT c). Operands enter through a valid/ready handshake and pass through two register stages. The result leaves through a second valid/ready handshake, together with reduction flags. It sits between operand sources and downstream consumers in the combinational-circuits portfolio as the first registered, flow-controlled logic block.

---
 rtl/logic_unit_pipe_if.sv | 32 +++
 rtl/logic_unit_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe_if.sv
// Operand/result stream bundle for logic_unit_pipe.
// The slave side is the logic unit; the master side is the operand source
// that also acts as the result consumer.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  // Operand beat (upstream handshake)
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  // Result beat (downstream handshake)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ones;
  logic             parity;

  modport master (
    output in_valid, op, a, b, c, out_ready,
    input  in_ready, out_valid, y, zero, ones, parity
  );

  modport slave (
    input  in_valid, op, a, b, c, out_ready,
    output in_ready, out_valid, y, zero, ones, parity
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage, flow-controlled bitwise logic unit.
// S1 captures the operand beat, S2 holds the result and its reduction flags.
// Both stages advance together when the consumer is able to take data, so the
// unit holds at most two beats and never reorders or drops one.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOTC  = 3'd2,
    OP_XOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_AOINV = 3'd7
  } op_e;

  // Bitwise result for the selected operation; unused operands are ignored.
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (op_e'(op))
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NOTC:  r = ~c;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_AOINV: r = (a & b) | ~c;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Reduction flags packed as {zero, ones, parity}; for WIDTH=1 this gives
  // zero=~y, ones=y, parity=y without any special casing.
  function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] v);
    return {~|v, &v, ^v};
  endfunction

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [WIDTH-1:0] s1_c_q,     s1_c_d;

  // Stage 2 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q,         y_d;
  logic             zero_q,      zero_d;
  logic             ones_q,      ones_d;
  logic             parity_q,    parity_d;

  // Flow control
  logic             s2_take;
  logic             in_ready;
  logic             accept;

  // Stage-2 combinational result computed from S1 contents
  logic [WIDTH-1:0] y_calc;
  logic [2:0]       flags_calc;

  // Handshake decisions depend only on registered state and out_ready, so
  // in_ready has no combinational path from in_valid.
  always_comb begin
    s2_take  = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_take;
    accept   = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.ones      = ones_q;
  assign bus.parity    = parity_q;

  // ---- Stage 1: operand capture ----

  // S1 next state: refill whenever the slot is free or draining this cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
    end
    if (accept) begin
      s1_op_d = bus.op;
      s1_a_d  = bus.a;
      s1_b_d  = bus.b;
      s1_c_d  = bus.c;
    end
  end

  // S1 register with asynchronous clear of both control and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
    end
  end

  // ---- Stage 2: result and flags ----

  // Evaluate the selected operation and its flags from the S1 beat.
  always_comb begin
    y_calc     = logic_op(s1_op_q, s1_a_q, s1_b_q, s1_c_q);
    flags_calc = flags_of(y_calc);
  end

  // S2 next state: advance only when the consumer can take data; the result
  // payload is refreshed only by a real beat so it stays put while idle.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    if (s2_take) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d      = y_calc;
        zero_d   = flags_calc[2];
        ones_d   = flags_calc[1];
        parity_d = flags_calc[0];
      end
    end
  end

  // S2 register; out_valid and the payload drop as soon as rst_n goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
    end
  end

endmodule
